// File: rtl/fifo_level.sv
// -----------------------------------------------------------------------------
// fifo_level
//   Synchronous first-word-fall-through FIFO with occupancy count,
//   almost-full / almost-empty thresholds, synchronous flush and sticky
//   overflow / underflow error flags. All status outputs are registered and
//   computed from the next-state count, so they change only on clk_i edges.
//
// Ports
//   clk_i           single clock, rising edge
//   rst_ni          asynchronous active-low reset
//   wr_i            write request (w_data_i is pushed when accepted)
//   rd_i            read request (pops the word currently on r_data_o)
//   flush_i         synchronous clear of contents; overrides wr_i / rd_i
//   clr_err_i       synchronous clear of the sticky error flags
//   w_data_i        write data
//   r_data_o        head-of-FIFO data, meaningful only while empty_o = 0
//   count_o         occupancy, 0 .. 2**AddrBits
//   empty_o         count_o == 0
//   full_o          count_o == 2**AddrBits
//   almost_empty_o  count_o <= AlmostEmptyTh
//   almost_full_o   count_o >= AlmostFullTh
//   overflow_o      sticky: write seen while full and not accepted
//   underflow_o     sticky: read seen while empty
// -----------------------------------------------------------------------------
module fifo_level #(
    parameter int WordLength    = 8,
    parameter int AddrBits      = 3,
    parameter int AlmostFullTh  = 6,
    parameter int AlmostEmptyTh = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic [WordLength-1:0] w_data_i,
    output logic [WordLength-1:0] r_data_o,
    output logic [AddrBits:0]     count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int                Depth     = 2 ** AddrBits;
    localparam logic [AddrBits:0] DepthCnt  = (AddrBits + 1)'(Depth);
    localparam logic [AddrBits:0] AfTh      = (AddrBits + 1)'(AlmostFullTh);
    localparam logic [AddrBits:0] AeTh      = (AddrBits + 1)'(AlmostEmptyTh);
    localparam logic [AddrBits:0] CntOne    = (AddrBits + 1)'(1);
    localparam logic [AddrBits-1:0] PtrOne  = AddrBits'(1);
    localparam logic              AfAtReset = (AlmostFullTh == 0);

    logic [WordLength-1:0] mem_q [Depth];

    logic [AddrBits-1:0] w_ptr_q, r_ptr_q, w_ptr_d, r_ptr_d;
    logic [AddrBits:0]   count_q, count_d;
    logic                empty_q, full_q, aempty_q, afull_q, ovf_q, unf_q;
    logic                ovf_d, unf_d;
    logic                wr_acc, rd_acc;

    // A full FIFO still accepts a write when a read frees the head slot in the
    // same cycle; flush suppresses both operations outright.
    assign wr_acc = ~flush_i & wr_i & (~full_q | rd_i);
    assign rd_acc = ~flush_i & rd_i & ~empty_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (flush_i) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_acc) w_ptr_d = w_ptr_q + PtrOne;
            if (rd_acc) r_ptr_d = r_ptr_q + PtrOne;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Sticky errors: a new event in the clearing cycle wins over the clear.
    assign ovf_d = (~flush_i & wr_i & ~rd_i & full_q) | (ovf_q & ~clr_err_i);
    assign unf_d = (~flush_i & rd_i & empty_q)        | (unf_q & ~clr_err_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= AfAtReset;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DepthCnt);
            aempty_q <= (count_d <= AeTh);
            afull_q  <= (count_d >= AfTh);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // behind a valid pointer/count, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[w_ptr_q] <= w_data_i;
    end

    assign r_data_o       = mem_q[r_ptr_q];
    assign count_o        = count_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// -----------------------------------------------------------------------------
// tb_fifo_level
//   Directed bench for fifo_level (WordLength=8, depth 8, AF=6, AE=2).
//   Inputs change 1 ns after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_fifo_level;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       wr_i, rd_i, flush_i, clr_err_i;
    logic [7:0] w_data_i;
    logic [7:0] r_data_o;
    logic [3:0] count_o;
    logic       empty_o, full_o, almost_empty_o, almost_full_o;
    logic       overflow_o, underflow_o;

    int n_vec = 0;
    int n_err = 0;

    fifo_level #(
        .WordLength   (8),
        .AddrBits     (3),
        .AlmostFullTh (6),
        .AlmostEmptyTh(2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_i          (wr_i),
        .rd_i          (rd_i),
        .flush_i       (flush_i),
        .clr_err_i     (clr_err_i),
        .w_data_i      (w_data_i),
        .r_data_o      (r_data_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_empty_o(almost_empty_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the edge with inputs idle.
    task automatic op(input logic wr, input logic rd, input logic fl,
                      input logic clr, input logic [7:0] d);
        wr_i = wr; rd_i = rd; flush_i = fl; clr_err_i = clr; w_data_i = d;
        @(posedge clk_i);
        #1;
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0; w_data_i = '0;
        #12;
        // ---- reset values ----
        check("rst_count",  32'(count_o),        0);
        check("rst_empty",  32'(empty_o),        1);
        check("rst_aempty", 32'(almost_empty_o), 1);
        check("rst_full",   32'(full_o),         0);
        check("rst_afull",  32'(almost_full_o),  0);
        check("rst_ovf",    32'(overflow_o),     0);
        check("rst_unf",    32'(underflow_o),    0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_empty", 32'(empty_o), 1);

        // ---- fill 0x01..0x08 ----
        for (int i = 1; i <= 8; i++) begin
            op(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            check("fill_count",  32'(count_o),        32'(i));
            check("fill_aempty", 32'(almost_empty_o), 32'(i <= 2));
            check("fill_afull",  32'(almost_full_o),  32'(i >= 6));
            check("fill_full",   32'(full_o),         32'(i == 8));
            check("fill_empty",  32'(empty_o),        0);
            check("fill_head",   32'(r_data_o),       32'h01);
        end

        // ---- overflow then drain ----
        op(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        check("ovf_flag",  32'(overflow_o), 1);
        check("ovf_count", 32'(count_o),    8);
        check("ovf_full",  32'(full_o),     1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", 32'(r_data_o), 32'(i));
            op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            check("drain_count", 32'(count_o), 32'(8 - i));
        end
        check("drain_empty", 32'(empty_o),     1);
        check("drain_unf",   32'(underflow_o), 0);
        check("drain_ovf",   32'(overflow_o),  1);
        op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_ovf", 32'(overflow_o), 0);

        // ---- simultaneous wr/rd while empty ----
        op(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        check("er_count", 32'(count_o),     1);
        check("er_unf",   32'(underflow_o), 1);
        check("er_data",  32'(r_data_o),    32'h55);
        check("er_empty", 32'(empty_o),     0);
        op(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("er_pop_count", 32'(count_o),     0);
        check("er_clr_unf",   32'(underflow_o), 0);

        // ---- simultaneous wr/rd while full ----
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
        check("fr_pre_full", 32'(full_o), 1);
        op(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        check("fr_count", 32'(count_o),    8);
        check("fr_full",  32'(full_o),     1);
        check("fr_ovf",   32'(overflow_o), 0);
        check("fr_head",  32'(r_data_o),   32'h11);
        for (int i = 0; i < 8; i++) begin
            check("fr_data", 32'(r_data_o), (i == 7) ? 32'h99 : 32'(8'h11 + i));
            op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        check("fr_empty", 32'(empty_o), 1);

        // ---- pointer wrap with count held at 3 ----
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            check("wrap_data", 32'(r_data_o), 32'(8'h20 + i));
            op(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h23 + i));
            check("wrap_count", 32'(count_o), 3);
        end
        check("wrap_tail", 32'(r_data_o), 32'h34);

        // ---- flush at count 5 with wr/rd asserted ----
        op(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
        op(1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
        check("fl_pre_count", 32'(count_o), 5);
        op(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        check("fl_count",  32'(count_o),     0);
        check("fl_empty",  32'(empty_o),     1);
        check("fl_full",   32'(full_o),      0);
        check("fl_ovf",    32'(overflow_o),  0);
        check("fl_unf",    32'(underflow_o), 0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        check("fl_wr_data",  32'(r_data_o), 32'h3C);
        check("fl_wr_count", 32'(count_o),  1);
        op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // ---- async reset mid-stream at count 4 ----
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        check("ar_pre_count", 32'(count_o), 4);
        #2 rst_ni = 1'b0;
        #1;
        check("ar_count",  32'(count_o),        0);
        check("ar_empty",  32'(empty_o),        1);
        check("ar_aempty", 32'(almost_empty_o), 1);
        check("ar_afull",  32'(almost_full_o),  0);
        check("ar_full",   32'(full_o),         0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("ar_unf",      32'(underflow_o), 1);
        check("ar_unf_cnt",  32'(count_o),     0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous first-word-fall-through FIFO that succeeds the basic UART buffer. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, defined simultaneous read/write at both boundaries, and sticky overflow/underflow error flags. It sits between the UART receiver/transmitter datapaths and the bus-side register interface, with one instance per direction.

## Interface
- WordLength, 8, data word width in bits
- AddrBits, 3, address bits; depth = 2**AddrBits (must be ≥1)
- AlmostFullTh, 6, almost_full_o asserted when count ≥ AlmostFullTh (range 1..depth)
- AlmostEmptyTh, 2, almost_empty_o asserted when count ≤ AlmostEmptyTh (range 0..depth-1)

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- wr_i  input  1  write request
- rd_i  input  1  read request (pops current r_data_o)
- flush_i  input  1  synchronous clear of FIFO contents
- clr_err_i  input  1  synchronous clear of sticky error flags
- w_data_i  input  WordLength  write data
- r_data_o  output  WordLength  head-of-FIFO data, valid only when empty_o=0
- count_o  output  AddrBits+1  current occupancy, 0..2**AddrBits
- empty_o  output  1  count_o == 0
- full_o  output  1  count_o == 2**AddrBits
- almost_empty_o  output  1  count_o ≤ AlmostEmptyTh
- almost_full_o  output  1  count_o ≥ AlmostFullTh
- overflow_o  output  1  sticky: write attempted while full and not accepted
- underflow_o  output  1  sticky: read attempted while empty

## Operation
- Storage: 2**AddrBits × WordLength register array. Contents are not reset. Write and read pointers are AddrBits wide and wrap modulo depth.
- The count register is AddrBits+1 bits wide. Flags are derived from the next-state count and registered, so all flags are glitch-free registered outputs.
- Priority within a cycle: flush_i first, then read/write.
- flush_i=1: pointers → 0, count → 0, empty=1, full=0. wr_i/rd_i are ignored that cycle, with no error flagged. The array is not cleared. Error flags are unaffected.
- Write accepted (wr_acc) when wr_i & (~full | rd_i): the array is written at w_ptr and w_ptr increments.
- Read accepted (rd_acc) when rd_i & ~empty: r_ptr increments.
- Count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Boundary cases:
  - Empty with wr_i&rd_i: write accepted, read rejected. underflow_o sets and count → 1.
  - Full with wr_i&rd_i: both accepted. Head word is read and new word is written to the freed slot; count stays at depth and no overflow.
  - Full with wr_i only: write dropped, overflow_o sets, state unchanged.
  - Empty with rd_i only: underflow_o sets, state unchanged.
- Error flags: set on the condition, held until clr_err_i=1 or reset. If set and clear occur in the same cycle, set wins.
- r_data_o = array[r_ptr], combinational from registered pointer (FWFT). Value is don't-care while empty.

## Timing
- Reset (rst_ni=0, asynchronous): w_ptr=0, r_ptr=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AlmostFullTh==0 ? 1 : 0), which is 0 for legal values, overflow_o=0, underflow_o=0.
- Reset deassertion is synchronised externally. The first accepted op is on the first rising edge with rst_ni=1.
- Write-to-read latency: word written at edge N appears on r_data_o and empty_o falls after edge N, so it is readable in cycle N+1.
- Read: r_data_o advances to the next word immediately after the edge that accepts rd_i.
- All flags and count_o reflect the accepted operations one edge after the requests are sampled.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight requests are lost.
- Throughput: one write and one read per cycle sustained.

## Test plan
Configuration for all scenarios: WordLength=8, AddrBits=3 (depth 8), AlmostFullTh=6, AlmostEmptyTh=2.

- **Reset and fill:** After reset, write 0x01..0x08 on consecutive cycles.
  - Reset: empty_o=1, almost_empty_o=1, count_o=0.
  - Fill: count_o steps 1..8; almost_empty_o drops at count 3; almost_full_o rises at count 6; full_o=1 at count 8.
- **Overflow then drain:** From full, write 0xAA.
  - Write: overflow_o=1, count_o stays 8.
  - Read 8 words: r_data_o sequence 0x01..0x08, 0xAA never appears, empty_o=1 at end.
  - Pulse clr_err_i: overflow_o=0.
- **Simultaneous read/write at both boundaries:**
  - Empty with wr_i=rd_i=1 and data 0x55: count_o=1, underflow_o=1, r_data_o=0x55.
  - Full (0x10..0x17) with wr_i=rd_i=1 and data 0x99: count_o stays 8, full_o=1, 0x10 popped, last of the next 8 reads is 0x99.
- **Pointer wrap:** Perform 20 cycles of write+read with count held at 3.
  - Data order is preserved across wrap, and count_o=3 throughout.
- **Flush:** At count 5, assert flush_i together with wr_i=1 and rd_i=1.
  - Next cycle: count_o=0, empty_o=1, no error flags.
  - A subsequent write of 0x3C reads back 0x3C.
- **Async reset mid-stream:** Drop rst_ni at count 4 between clock edges.
  - Outputs go to reset values before the next edge; a post-reset read attempt sets underflow_o.
